// File: rtl/spi_interface.sv
// SPI master for a 12-bit ADC128S022-style converter: continuous 16-clock frames,
// channel address out on saddr, MSB-first result deserialised into data_out.
module spi_interface #(
   parameter logic [2:0]         CHANNEL = 3'd0,
   localparam int unsigned       DATA_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              sclk,
   output logic              cs_n,
   input  logic              sdat,
   output logic              saddr,
   output logic [DATA_W-1:0] data_out,
   output logic              end_of_conversion
);

   localparam int unsigned CNT_W     = 4;
   localparam int unsigned FIRST_BIT = 4;
   localparam int unsigned LAST_BIT  = 15;
   localparam int unsigned SHIFT_W   = DATA_W - 1;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cs_n_d;
   // DB0 goes straight into data_out, so only DB11..DB1 need holding.
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0]  data_d;
   logic               eoc_d;
   logic               saddr_d;

   // Next-state for the rising-edge registers.
   always_comb begin
      cnt_d   = cnt_q;
      cs_n_d  = 1'b0;
      shift_d = shift_q;
      data_d  = data_out;
      eoc_d   = 1'b0;
      if (!cs_n) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q >= CNT_W'(FIRST_BIT) && cnt_q != CNT_W'(LAST_BIT)) begin
            shift_d = {shift_q[SHIFT_W-2:0], sdat};
         end
         if (cnt_q == CNT_W'(LAST_BIT)) begin
            data_d = {shift_q, sdat};
            eoc_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q             <= '0;
         cs_n              <= 1'b1;
         shift_q           <= '0;
         data_out          <= '0;
         end_of_conversion <= 1'b0;
      end else begin
         cnt_q             <= cnt_d;
         cs_n              <= cs_n_d;
         shift_q           <= shift_d;
         data_out          <= data_d;
         end_of_conversion <= eoc_d;
      end
   end

   // Address bits for frame cycles 2..4; zero elsewhere.
   always_comb begin
      saddr_d = 1'b0;
      case (cnt_q)
         CNT_W'(2): saddr_d = CHANNEL[2];
         CNT_W'(3): saddr_d = CHANNEL[1];
         CNT_W'(4): saddr_d = CHANNEL[0];
         default:   saddr_d = 1'b0;
      endcase
   end

   // Launched on falling clk so DIN is stable around each rising sclk.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) saddr <= 1'b0;
      else        saddr <= saddr_d;
   end

   assign sclk = cs_n ? 1'b1 : clk;

endmodule

// File: tb/tb_spi_interface.sv
// Self-checking bench for spi_interface: emulates the ADC DOUT pin frame by frame
// and checks strobe, captured word, address bits and reset behaviour.
module tb_spi_interface;

   localparam logic [2:0] CHAN = 3'd5;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        sdat  = 1'b0;
   logic        sclk, cs_n, saddr, end_of_conversion;
   logic [11:0] data_out;

   int          checks = 0;
   int          errors = 0;
   logic [11:0] exp_data = 12'h000;

   always #5 clk = ~clk;

   spi_interface #(.CHANNEL(CHAN)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .sdat(sdat),
      .saddr(saddr), .data_out(data_out), .end_of_conversion(end_of_conversion)
   );

   // Address bit the ADC expects during frame cycle k.
   function automatic logic exp_saddr(input int k);
      logic [2:0] ch;
      ch = CHAN;
      case (k)
         2:       return ch[2];
         3:       return ch[1];
         4:       return ch[0];
         default: return 1'b0;
      endcase
   endfunction

   // One frame: 4 leading bits (ignored by the DUT), then DB11..DB0.
   task automatic run_frame(input logic [11:0] code, input logic lead, input int abort_at);
      logic exp_eoc;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k < 4) sdat = lead;
         else       sdat = code[15-k];
         #1;
         checks++;
         if (saddr !== exp_saddr(k)) begin
            errors++;
            $display("FAIL saddr_fall cycle %0d: got %b want %b", k, saddr, exp_saddr(k));
         end
         checks++;
         if (sclk !== 1'b0) begin
            errors++;
            $display("FAIL sclk_low cycle %0d: got %b want 0", k, sclk);
         end
         if (k == abort_at) return;
         @(posedge clk);
         #1;
         exp_eoc = (k == 15);
         if (k == 15) exp_data = code;
         checks++;
         if (end_of_conversion !== exp_eoc) begin
            errors++;
            $display("FAIL eoc cycle %0d: got %b want %b", k, end_of_conversion, exp_eoc);
         end
         checks++;
         if (data_out !== exp_data) begin
            errors++;
            $display("FAIL data_out cycle %0d: got %h want %h", k, data_out, exp_data);
         end
         checks++;
         if (saddr !== exp_saddr(k)) begin
            errors++;
            $display("FAIL saddr_hold cycle %0d: got %b want %b", k, saddr, exp_saddr(k));
         end
         checks++;
         if (cs_n !== 1'b0 || sclk !== 1'b1) begin
            errors++;
            $display("FAIL cs_sclk_run cycle %0d: got cs_n=%b sclk=%b want 0 1", k, cs_n, sclk);
         end
      end
   endtask

   // Immediate (clockless) reset values.
   task automatic check_reset_state(input string tag);
      checks++;
      if (cs_n !== 1'b1 || sclk !== 1'b1 || saddr !== 1'b0) begin
         errors++;
         $display("FAIL %s_pins: got cs_n=%b sclk=%b saddr=%b want 1 1 0", tag, cs_n, sclk, saddr);
      end
      checks++;
      if (data_out !== 12'h000 || end_of_conversion !== 1'b0) begin
         errors++;
         $display("FAIL %s_data: got data=%h eoc=%b want 000 0", tag, data_out, end_of_conversion);
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (cs_n !== 1'b1 || sclk !== 1'b1) begin
         errors++;
         $display("FAIL release_idle: got cs_n=%b sclk=%b want 1 1", cs_n, sclk);
      end
      @(posedge clk);
      #1;
      exp_data = 12'h000;
      checks++;
      if (cs_n !== 1'b0 || data_out !== 12'h000 || end_of_conversion !== 1'b0) begin
         errors++;
         $display("FAIL first_edge: got cs_n=%b data=%h eoc=%b want 0 000 0",
                  cs_n, data_out, end_of_conversion);
      end
   endtask

   task automatic test_reset();
      sdat = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check_reset_state("reset");
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset_held");
      release_reset();
   endtask

   task automatic test_fixed_pattern();
      for (int f = 0; f < 3; f++) run_frame(12'hA5C, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      logic [11:0] codes [4];
      codes = '{12'h000, 12'hFFF, 12'h800, 12'h001};
      foreach (codes[i]) run_frame(codes[i], 1'b0, -1);
   endtask

   task automatic test_leading_ones();
      for (int f = 0; f < 4; f++) run_frame(12'($urandom), 1'b1, -1);
   endtask

   task automatic test_random();
      for (int f = 0; f < 20; f++) run_frame(12'($urandom), 1'($urandom), -1);
   endtask

   task automatic test_reset_mid_frame();
      logic [11:0] c;
      c = 12'($urandom_range(1, 4095));
      run_frame(c, 1'b0, -1);
      run_frame(12'($urandom), 1'b0, 9);
      #1 rst_n = 1'b0;
      #1;
      check_reset_state("midframe");
      release_reset();
      for (int f = 0; f < 2; f++) run_frame(12'($urandom), 1'($urandom), -1);
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 4096; i++) run_frame(12'(i), 1'($urandom), -1);
   endtask

   initial begin
      test_reset();
      test_fixed_pattern();
      test_back_to_back();
      test_leading_ones();
      test_random();
      test_reset_mid_frame();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
